// File: rtl/ct_pkg.sv
// rtl/ct_pkg.sv - shared state enum, count type and preset saturation helper for ct_down_timer
package ct_pkg;

    typedef logic [6:0] count_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } ct_state_e;

    function automatic count_t ct_sat(input count_t v, input count_t max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/ct_down_mod_N.sv
// rtl/ct_down_mod_N.sv - one modulo-N down-counting digit with load priority and zero flag
module ct_down_mod_N
    import ct_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  count_t load_val,
    input  logic   en,
    input  count_t modulus,
    output count_t ct_out,
    output logic   ct_min
);

    count_t r_cnt;

    // Decrementing through zero wraps to modulus-1, which is the borrow seen by the next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en) begin
            r_cnt <= (r_cnt == '0) ? count_t'(modulus - 7'd1) : count_t'(r_cnt - 7'd1);
        end
    end

    assign ct_out = r_cnt;
    assign ct_min = (r_cnt == '0);

endmodule

// File: rtl/ct_down_timer.sv
// rtl/ct_down_timer.sv - minutes:seconds countdown timer with alarm; CT_AUTO_RELOAD_EN restarts from the last preset on expiry
module ct_down_timer
    import ct_pkg::*;
#(
    parameter int SEC_MOD     = 60,
    parameter int MIN_MOD     = 60,
    parameter int ALARM_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [6:0] load_min,
    input  logic [6:0] load_sec,
    output logic [6:0] min_out,
    output logic [6:0] sec_out,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam count_t SEC_MAX = count_t'(SEC_MOD - 1);
    localparam count_t MIN_MAX = count_t'(MIN_MOD - 1);
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    ct_state_e  r_state;
    ct_state_e  w_state_nx;
    logic       r_done;
    logic       r_alarm;
    logic [7:0] r_alarm_cnt;

    count_t w_sat_min, w_sat_sec;
    count_t w_ld_min, w_ld_sec;
    count_t w_min, w_sec;
    logic   w_ld;
    logic   w_sec_zero, w_min_zero, w_count_zero;
    logic   w_run_tick, w_min_en, w_expire;

    assign w_sat_min = ct_sat(load_min, MIN_MAX);
    assign w_sat_sec = ct_sat(load_sec, SEC_MAX);

    // A concurrent load suppresses counting so the preset lands undecremented.
    assign w_run_tick   = (r_state == ST_RUN) && tick && !load;
    assign w_min_en     = w_run_tick && w_sec_zero;
    assign w_count_zero = w_sec_zero && w_min_zero;
    assign w_expire     = w_run_tick && w_min_zero && (w_sec == 7'd1);

`ifdef CT_AUTO_RELOAD_EN
    count_t r_pre_min, r_pre_sec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_min <= '0;
            r_pre_sec <= '0;
        end else if (load) begin
            r_pre_min <= w_sat_min;
            r_pre_sec <= w_sat_sec;
        end
    end

    assign w_ld     = load || w_expire;
    assign w_ld_min = load ? w_sat_min : r_pre_min;
    assign w_ld_sec = load ? w_sat_sec : r_pre_sec;
`else
    assign w_ld     = load;
    assign w_ld_min = w_sat_min;
    assign w_ld_sec = w_sat_sec;
`endif

    ct_down_mod_N u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_ld),
        .load_val (w_ld_sec),
        .en       (w_run_tick),
        .modulus  (count_t'(SEC_MOD)),
        .ct_out   (w_sec),
        .ct_min   (w_sec_zero)
    );

    ct_down_mod_N u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_ld),
        .load_val (w_ld_min),
        .en       (w_min_en),
        .modulus  (count_t'(MIN_MOD)),
        .ct_out   (w_min),
        .ct_min   (w_min_zero)
    );

    always_comb begin
        w_state_nx = r_state;
        if (load) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: if (start && !w_count_zero) w_state_nx = ST_RUN;
                ST_RUN: begin
                    if (w_expire)   w_state_nx = ST_DONE;
                    else if (pause) w_state_nx = ST_PAUSE;
                end
`ifdef CT_AUTO_RELOAD_EN
                ST_DONE: if (!w_count_zero) w_state_nx = ST_RUN;
`else
                ST_DONE: w_state_nx = ST_DONE;
`endif
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_expire;
        end
    end

    // The expiring tick itself does not count toward the alarm duration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else if (load) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else if (w_expire) begin
            r_alarm     <= 1'b1;
            r_alarm_cnt <= '0;
        end else if (r_alarm && tick) begin
            if (r_alarm_cnt == ALARM_LAST) begin
                r_alarm     <= 1'b0;
                r_alarm_cnt <= '0;
            end else begin
                r_alarm_cnt <= r_alarm_cnt + 8'd1;
            end
        end
    end

    assign min_out = w_min;
    assign sec_out = w_sec;
    assign running = (r_state == ST_RUN);
    assign done    = r_done;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_ct_down_timer.sv
// tb/tb_ct_down_timer.sv - directed and randomized checks of ct_down_timer against a total-seconds reference model
module tb_ct_down_timer;

    localparam int SEC_MOD     = 60;
    localparam int MIN_MOD     = 60;
    localparam int ALARM_TICKS = 4;
`ifdef CT_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [6:0] load_min = '0, load_sec = '0;
    logic [6:0] min_out, sec_out;
    logic       running, done, alarm;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining time as a single number of seconds.
    int m_total, m_preset, m_alarm_left;
    bit m_running, m_expired, m_done;

    ct_down_timer #(.SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD), .ALARM_TICKS(ALARM_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .start(start), .pause(pause),
        .load_min(load_min), .load_sec(load_sec), .min_out(min_out), .sec_out(sec_out),
        .running(running), .done(done), .alarm(alarm)
    );

    initial forever #5 clk = ~clk;

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic model_reset();
        m_total = 0; m_preset = 0; m_alarm_left = 0;
        m_running = 0; m_expired = 0; m_done = 0;
    endtask

    task automatic model_edge();
        bit expire;
        expire = 0;
        m_done = 0;
        if (load) begin
            m_total = sat(int'(load_min), MIN_MOD - 1) * SEC_MOD + sat(int'(load_sec), SEC_MOD - 1);
            m_preset = m_total;
            m_running = 0; m_expired = 0; m_alarm_left = 0;
        end else begin
            if (m_expired) begin
                if (AUTO && m_total != 0) begin m_expired = 0; m_running = 1; end
            end else if (m_running) begin
                if (tick) begin
                    m_total = m_total - 1;
                    if (m_total == 0) begin
                        expire = 1; m_running = 0; m_expired = 1; m_done = 1;
                        if (AUTO) m_total = m_preset;
                    end
                end
                if (!expire && pause) m_running = 0;
            end else if (start && m_total != 0) begin
                m_running = 1;
            end
            if (expire) m_alarm_left = ALARM_TICKS;
            else if (m_alarm_left > 0 && tick) m_alarm_left = m_alarm_left - 1;
        end
    endtask

    task automatic cyc(input bit t, input bit l, input bit s, input bit p,
                       input logic [6:0] lm, input logic [6:0] ls);
        tick = t; load = l; start = s; pause = p; load_min = lm; load_sec = ls;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({min_out, sec_out, running, done, alarm} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got %0d:%0d r%b d%b a%b want all zero", min_out, sec_out, running, done, alarm);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_borrow();
        cyc(0, 1, 0, 0, 7'd1, 7'd5);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (sec_out !== 7'd59 || min_out !== 7'd0) begin
            errors++;
            $display("FAIL borrow_count got %0d:%0d want 0:59", min_out, sec_out);
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL borrow_running got %b want 1", running);
        end
    endtask

    task automatic test_done_alarm();
        cyc(0, 1, 0, 0, 7'd0, 7'd2);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (sec_out !== 7'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL expire_pre got sec %0d done %b want 1 0", sec_out, done);
        end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if ({min_out, sec_out} !== 14'd0 || done !== 1'b1 || alarm !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL expire_entry got %0d:%0d d%b a%b r%b want 0:0 d1 a1 r0", min_out, sec_out, done, alarm, running);
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (done !== 1'b0 || alarm !== 1'b1) begin
            errors++;
            $display("FAIL done_width got d%b a%b want d0 a1", done, alarm);
        end
        for (int i = 0; i < ALARM_TICKS - 1; i++) cyc(1, 0, 1, 0, 0, 0);
        checks++;
        if (alarm !== 1'b1 || running !== 1'b0 || {min_out, sec_out} !== 14'd0) begin
            errors++;
            $display("FAIL alarm_hold got a%b r%b %0d:%0d want a1 r0 0:0", alarm, running, min_out, sec_out);
        end
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (alarm !== 1'b0 || {min_out, sec_out} !== 14'd0) begin
            errors++;
            $display("FAIL alarm_fall got a%b %0d:%0d want a0 0:0", alarm, min_out, sec_out);
        end
    endtask

    task automatic test_auto();
        cyc(0, 1, 0, 0, 7'd0, 7'd3);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if (done !== 1'b1 || {min_out, sec_out} !== {7'd0, 7'd3} || alarm !== 1'b1) begin
            errors++;
            $display("FAIL auto_entry got d%b a%b %0d:%0d want d1 a1 0:3", done, alarm, min_out, sec_out);
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (running !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL auto_restart got r%b d%b want r1 d0", running, done);
        end
    endtask

    task automatic test_pause();
        cyc(0, 1, 0, 0, 7'd0, 7'd10);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        checks++;
        if (running !== 1'b0 || sec_out !== 7'd7) begin
            errors++;
            $display("FAIL pause_wins got r%b sec %0d want r0 7", running, sec_out);
        end
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        checks++;
        if ({min_out, sec_out} !== {7'd0, 7'd6} || running !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume got %0d:%0d r%b want 0:6 r1", min_out, sec_out, running);
        end
    endtask

    task automatic test_saturate();
        cyc(1, 1, 1, 0, 7'd75, 7'd99);
        checks++;
        if ({min_out, sec_out} !== {7'd59, 7'd59} || running !== 1'b0) begin
            errors++;
            $display("FAIL saturate got %0d:%0d r%b want 59:59 r0", min_out, sec_out, running);
        end
        cyc(0, 1, 0, 0, 7'd0, 7'd0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        checks++;
        if (running !== 1'b0 || {min_out, sec_out} !== 14'd0) begin
            errors++;
            $display("FAIL zero_start got r%b %0d:%0d want r0 0:0", running, min_out, sec_out);
        end
    endtask

    task automatic test_async_reset();
        bit saw_done;
        cyc(0, 1, 0, 0, 7'd0, 7'd5);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({min_out, sec_out, running, done, alarm} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got %0d:%0d r%b d%b a%b want all zero", min_out, sec_out, running, done, alarm);
        end
        model_reset();
        #2 rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            if (done !== 1'b0 || running !== 1'b0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done got done/running activity want none");
        end
    endtask

    task automatic test_random();
        logic [6:0] lm, ls;
        for (int i = 0; i < 1500; i++) begin
            lm = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 1));
            ls = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6));
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, lm, ls);
            checks++;
            if ({min_out, sec_out, running, done, alarm} !==
                {7'(m_total / SEC_MOD), 7'(m_total % SEC_MOD), m_running, m_done, (m_alarm_left > 0)}) begin
                errors++;
                $display("FAIL random_cycle%0d got %0d:%0d r%b d%b a%b want %0d:%0d r%b d%b a%b", i,
                         min_out, sec_out, running, done, alarm,
                         m_total / SEC_MOD, m_total % SEC_MOD, m_running, m_done, m_alarm_left > 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_borrow();
`ifdef CT_AUTO_RELOAD_EN
        test_auto();
`else
        test_done_alarm();
`endif
        test_pause();
        test_saturate();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
